// File: rtl/connect4_pkg.sv
// Shared board geometry, cell indexing and enumerations for the Connect-4 board engine.
package connect4_pkg;

   localparam int COLS    = 7;
   localparam int ROWS    = 6;
   localparam int WIN_LEN = 4;
   localparam int CELLS   = COLS * ROWS;

   typedef enum logic {
      RED = 1'b0,
      YEL = 1'b1
   } player_t;

   typedef enum logic [1:0] {
      NONE    = 2'b00,
      RED_WIN = 2'b01,
      YEL_WIN = 2'b10,
      DRAW    = 2'b11
   } result_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_PLACE,
      S_CHECK,
      S_DONE
   } state_t;

   // Row 0 is the top row, column 0 the left column.
   function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
      return 6'(col) + 6'(COLS) * 6'(row);
   endfunction

endpackage

// File: rtl/c4_cell_step.sv
// One-cell neighbour step along a win-check direction, with board-edge detection on col/row.
module c4_cell_step
   import connect4_pkg::*;
(
   input  logic [2:0] col,
   input  logic [2:0] row,
   input  logic [1:0] dir,
   input  logic       sign,
   output logic [2:0] nxt_col,
   output logic [2:0] nxt_row,
   output logic       in_bounds
);

   logic signed [4:0] dc;
   logic signed [4:0] dr;
   logic signed [4:0] c;
   logic signed [4:0] r;

   always_comb begin
      dc = 5'sd0;
      dr = 5'sd0;
      case (dir)
         2'd0:    dc = 5'sd1;
         2'd1:    dr = 5'sd1;
         2'd2:    begin dc = 5'sd1; dr = 5'sd1;  end
         default: begin dc = 5'sd1; dr = -5'sd1; end
      endcase
      if (sign) begin
         dc = -dc;
         dr = -dr;
      end
      // Widened signed arithmetic so stepping off col 0/6 never wraps into another row.
      c = $signed({2'b00, col}) + dc;
      r = $signed({2'b00, row}) + dr;
      in_bounds = !c[4] && (c < $signed(5'(COLS))) && !r[4] && (r < $signed(5'(ROWS)));
      nxt_col = c[2:0];
      nxt_row = r[2:0];
   end

endmodule

// File: rtl/board_state.sv
// Connect-4 board register and move engine: gravity scan, piece placement and
// a cell-per-cycle win walk over four directions.
module board_state
   import connect4_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             new_game,
   input  logic             move_valid,
   input  logic [2:0]       move_col,
   output logic             move_ready,
   output logic             move_err,
   output logic [CELLS-1:0] red_enc,
   output logic [CELLS-1:0] yel_enc,
   output logic             turn,
   output logic             game_over,
   output logic [1:0]       winner
);

   state_t           state, state_nx;
   logic [2:0]       col_q, row_q;
   logic [2:0]       cur_col, cur_row;
   logic [1:0]       dir_q;
   logic             side_q;
   logic [1:0]       steps_q;
   logic [2:0]       run_q;
   logic [5:0]       count_q;
   logic             win_q;

   logic [CELLS-1:0] occ, own;
   logic [2:0]       nxt_col, nxt_row;
   logic             nxt_in;
   logic             accept, col_ok, cell_empty, match, run_hit;

   assign move_ready = (state == S_IDLE) && !game_over;
   assign accept     = move_valid && move_ready;
   assign col_ok     = move_col < 3'(COLS);
   assign occ        = red_enc | yel_enc;
   assign own        = (turn == YEL) ? yel_enc : red_enc;
   assign cell_empty = !occ[cell_idx(col_q, row_q)];

   c4_cell_step u_step (
      .col       (cur_col),
      .row       (cur_row),
      .dir       (dir_q),
      .sign      (side_q),
      .nxt_col   (nxt_col),
      .nxt_row   (nxt_row),
      .in_bounds (nxt_in)
   );

   // A side keeps extending while the neighbour is in bounds, ours, and the step cap is not hit.
   assign match   = nxt_in && own[cell_idx(nxt_col, nxt_row)] && (steps_q < 2'(WIN_LEN - 1));
   assign run_hit = match && (({1'b0, run_q} + 4'd1) >= 4'(WIN_LEN));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept && col_ok) state_nx = S_SCAN;
         S_SCAN:  begin
            if (cell_empty)       state_nx = S_PLACE;
            else if (row_q == '0) state_nx = S_IDLE;
         end
         S_PLACE: state_nx = S_CHECK;
         S_CHECK: if (run_hit || (!match && side_q && dir_q == 2'd3)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           state <= S_IDLE;
      else if (new_game) state <= S_IDLE;
      else               state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red_enc <= '0; yel_enc <= '0; turn <= 1'b0; game_over <= 1'b0; winner <= NONE;
         move_err <= 1'b0; count_q <= '0; col_q <= '0; row_q <= '0; cur_col <= '0;
         cur_row <= '0; dir_q <= '0; side_q <= 1'b0; steps_q <= '0; run_q <= '0; win_q <= 1'b0;
      end else if (new_game) begin
         red_enc <= '0; yel_enc <= '0; turn <= 1'b0; game_over <= 1'b0; winner <= NONE;
         move_err <= 1'b0; count_q <= '0; col_q <= '0; row_q <= '0; cur_col <= '0;
         cur_row <= '0; dir_q <= '0; side_q <= 1'b0; steps_q <= '0; run_q <= '0; win_q <= 1'b0;
      end else begin
         move_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (!col_ok) begin
                     move_err <= 1'b1;
                  end else begin
                     col_q <= move_col;
                     row_q <= 3'(ROWS - 1);
                  end
               end
            end
            S_SCAN: begin
               if (!cell_empty) begin
                  if (row_q == '0) move_err <= 1'b1;
                  else             row_q    <= row_q - 3'd1;
               end
            end
            S_PLACE: begin
               if (turn == YEL) yel_enc[cell_idx(col_q, row_q)] <= 1'b1;
               else             red_enc[cell_idx(col_q, row_q)] <= 1'b1;
               count_q <= count_q + 6'd1;
               dir_q   <= '0;
               side_q  <= 1'b0;
               steps_q <= '0;
               run_q   <= 3'd1;
               cur_col <= col_q;
               cur_row <= row_q;
               win_q   <= 1'b0;
            end
            S_CHECK: begin
               if (match) begin
                  cur_col <= nxt_col;
                  cur_row <= nxt_row;
                  steps_q <= steps_q + 2'd1;
                  if (run_q != 3'b111) run_q <= run_q + 3'd1;
                  if (run_hit)         win_q <= 1'b1;
               end else begin
                  // Side finished: restart the walk from the placed piece.
                  cur_col <= col_q;
                  cur_row <= row_q;
                  steps_q <= '0;
                  if (!side_q) begin
                     side_q <= 1'b1;
                  end else begin
                     side_q <= 1'b0;
                     dir_q  <= dir_q + 2'd1;
                     run_q  <= 3'd1;
                  end
               end
            end
            S_DONE: begin
               if (win_q) begin
                  game_over <= 1'b1;
                  winner    <= (turn == YEL) ? YEL_WIN : RED_WIN;
               end else if (count_q == 6'(CELLS)) begin
                  game_over <= 1'b1;
                  winner    <= DRAW;
               end else begin
                  turn <= ~turn;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
